// File: rtl/rf_read_sequencer.sv
// rf_read_sequencer: presents a two-operand (rs1/rs2) read interface over a single-read-port
// register file and forwards write-back. Define RF_SEQ_BYPASS_EN for same-cycle write forwarding.
module rf_read_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rv1,
  output logic [DATA_W-1:0] rsp_rv2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_enable,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_indata,
  input  logic [DATA_W-1:0] rf_rv1
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0] rd_val;
  logic              rd_active;

  // Write-back is a pure pass-through; index 0 writes and writes under reset are dropped.
  assign rf_we     = wb_valid & (wb_rd != '0) & ~rst;
  assign rf_rd     = wb_rd;
  assign rf_indata = wb_data;
  assign rf_enable = rd_active | rf_we;

  assign rf_rs1  = (state_q == RD2) ? rs2_q : rs1_q;
  assign rd_val  = (rf_rs1 == '0) ? '0 : rf_rv1;
  assign rsp_rv1 = op1_q;
  assign rsp_rv2 = op2_q;

`ifdef RF_SEQ_BYPASS_EN
  logic wr_hit_rs1, wr_hit_rs2;
  assign wr_hit_rs1 = rf_we & (wb_rd == rs1_q);
  assign wr_hit_rs2 = rf_we & (wb_rd == rs2_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rd_active = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          state_d = RD1;
        end
      end
      RD1: begin
        rd_active = 1'b1;
        op1_d     = rd_val;
`ifdef RF_SEQ_BYPASS_EN
        if (wr_hit_rs1) op1_d = wb_data;
`endif
        state_d   = RD2;
      end
      RD2: begin
        rd_active = 1'b1;
        op2_d     = rd_val;
`ifdef RF_SEQ_BYPASS_EN
        // A write landing in RD2 must also refresh the already-captured op1.
        if (wr_hit_rs2) op2_d = wb_data;
        if (wr_hit_rs1) op1_d = wb_data;
`endif
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rd_active = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_read_sequencer.sv
// Scoreboard bench for rf_read_sequencer: a driver pushes expected operands computed from an
// architectural register model; a negedge monitor compares every response and protocol rule.
module tb_rf_read_sequencer;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, wb_valid;
  logic        rf_enable, rf_we;
  logic [4:0]  req_rs1, req_rs2, wb_rd, rf_rs1, rf_rd;
  logic [31:0] rsp_rv1, rsp_rv2, wb_data, rf_indata, rf_rv1;

  always #5 clk = ~clk;

  rf_read_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rv1(rsp_rv1), .rsp_rv2(rsp_rv2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_enable(rf_enable), .rf_we(rf_we), .rf_rs1(rf_rs1), .rf_rd(rf_rd),
    .rf_indata(rf_indata), .rf_rv1(rf_rv1)
  );

  // Register file attached to the DUT; index 0 returns junk so the DUT must force zero itself.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge clk) if (rf_enable && rf_we) rf_mem[rf_rd] <= rf_indata;
  assign rf_rv1 = (rf_rs1 == 5'd0) ? 32'hDEAD_BEEF : rf_mem[rf_rs1];

  // Architectural register state as seen by software: every accepted write-back lands here.
  logic [31:0] arch [32] = '{default: 32'h0};
  always @(posedge clk) if (!rst && wb_valid && wb_rd != 5'd0) arch[wb_rd] <= wb_data;

  function automatic logic [31:0] val(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : arch[r];
  endfunction

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct {
    logic [31:0] rv1;
    logic [31:0] rv2;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  bit finished = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  // Monitor: all DUT comparisons happen here, on the falling edge.
  bit          was_valid = 1'b0, was_rst = 1'b0, accepted = 1'b0;
  logic [31:0] held1, held2;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_rf_enable", 32'(rf_enable), 32'd0);
      was_valid = 1'b0;
      accepted  = 1'b0;
      was_rst   = 1'b1;
    end else begin
      if (was_rst) begin
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_rv1", rsp_rv1, 32'd0);
        check("post_rst_rv2", rsp_rv2, 32'd0);
      end
      if (accepted) check("idle_req_ready", 32'(req_ready), 32'd1);
      accepted = 1'b0;
      if (wb_valid || rf_we) begin
        check("rf_we", 32'(rf_we), 32'(wb_valid && wb_rd != 5'd0));
        if (rf_we) begin
          check("rf_rd", 32'(rf_rd), 32'(wb_rd));
          check("rf_indata", rf_indata, wb_data);
        end
      end
      if (rsp_valid && !was_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_latency", 32'(cnt), 32'(exp_q[0].cyc));
          check("rsp_rv1", rsp_rv1, exp_q[0].rv1);
          check("rsp_rv2", rsp_rv2, exp_q[0].rv2);
        end
        held1 = rsp_rv1;
        held2 = rsp_rv2;
      end else if (rsp_valid) begin
        check("hold_rv1", rsp_rv1, held1);
        check("hold_rv2", rsp_rv2, held2);
      end
      if (rsp_valid) check("resp_req_ready", 32'(req_ready), 32'd0);
      else if (exp_q.size() > 0 && cnt >= exp_q[0].cyc) begin
        check("rsp_missing", 32'(rsp_valid), 32'd1);
        void'(exp_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        accepted = 1'b1;
      end
      was_valid = rsp_valid && !rsp_ready;
      was_rst   = 1'b0;
    end
    if (done && !finished) begin
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      finished = 1'b1;
    end
  end

  task automatic rand_wb(input logic [4:0] r1, input logic [4:0] r2);
    int s;
    s        = int'($urandom_range(0, 5));
    wb_valid = (s < 4);
    case (s)
      0:       wb_rd = r1;
      1:       wb_rd = r2;
      2:       wb_rd = 5'd0;
      default: wb_rd = 5'($urandom_range(0, 31));
    endcase
    wb_data = $urandom();
  endtask

  // mode 0: random writes every cycle; mode 1/2/3: a single write in RD1/RD2/RESP; else none.
  task automatic phase_wb(input int mode, input int phase, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] drd, input logic [31:0] dval);
    if (mode == 0) rand_wb(r1, r2);
    else if (mode == phase) begin
      wb_valid = 1'b1;
      wb_rd    = drd;
      wb_data  = dval;
    end else wb_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic handshake(input logic [4:0] r1, input logic [4:0] r2, output int c);
    req_valid = 1'b1;
    req_rs1   = r1;
    req_rs2   = r2;
    wb_valid  = 1'b0;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (req_ready) break;
      if (i > 20) begin
        $display("FAIL handshake_timeout: req_ready stayed low (cycle %0d)", cnt);
        $fatal(1, "handshake timeout");
      end
    end
    c = cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [4:0] r1, input logic [4:0] r2, input int hold,
                         input int mode, input logic [4:0] drd, input logic [31:0] dval);
    int          c;
    logic [31:0] nb1, nb2;
    exp_t        e;
    handshake(r1, r2, c);
    nb1 = val(r1);                       // RD1: RF content before this cycle's write
    phase_wb(mode, 1, r1, r2, drd, dval);
    @(posedge clk); #1;
    nb2 = val(r2);                       // RD2
    phase_wb(mode, 2, r1, r2, drd, dval);
    @(posedge clk); #1;                  // RESP: arch now holds every write through RD2
`ifdef RF_SEQ_BYPASS_EN
    e.rv1 = val(r1);
    e.rv2 = val(r2);
`else
    e.rv1 = nb1;
    e.rv2 = nb2;
`endif
    e.cyc = c + 3;
    exp_q.push_back(e);
    phase_wb(mode, 3, r1, r2, drd, dval);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mode == 0) rand_wb(r1, r2); else wb_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (i > 10) begin
        $display("FAIL rsp_timeout: rsp_valid never rose (cycle %0d)", cnt);
        $fatal(1, "response timeout");
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    wb_valid  = 1'b0;
  endtask

  task automatic reset_in_rd2(input logic [4:0] r1, input logic [4:0] r2);
    int c;
    handshake(r1, r2, c);
    @(posedge clk); #1;                  // RD2
    rst      = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = r1;
    wb_data  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    rst      = 1'b0;
    wb_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; wb_valid = 1'b0;
    @(posedge clk); #1;

    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h22);
    run_req(5'd5, 5'd6, 0, 9, 5'd0, 32'h0);
    wb_write(5'd0, 32'hFFFF_FFFF);
    run_req(5'd0, 5'd0, 0, 9, 5'd0, 32'h0);
    run_req(5'd5, 5'd6, 5, 9, 5'd0, 32'h0);
    run_req(5'd3, 5'd5, 0, 9, 5'd0, 32'h0);

    for (int ph = 1; ph <= 3; ph++) begin
      wb_write(5'd7, 32'h1);
      run_req(5'd7, 5'd7, 0, ph, 5'd7, 32'hAB);
    end

    reset_in_rd2(5'd5, 5'd6);
    run_req(5'd5, 5'd6, 0, 9, 5'd0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) begin
        rand_wb(r1, r2);
        @(posedge clk); #1;
      end
      wb_valid = 1'b0;
      run_req(r1, r2, int'($urandom_range(0, 3)), 0, 5'd0, 32'h0);
    end

    repeat (4) @(posedge clk);
    #1;
    done = 1'b1;
    wait (finished);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
